display_scan_7seg: RTL and testbench
====================================

Name: display_scan_7seg

Overview:
- Downstream consumer of the frequency-indicator decoder.
- Takes its four 4-bit display codes (digit 0 = rightmost … digit 3 = leftmost) and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Provides per-digit anode scanning, an anti-ghosting blank gap between digits, tear-free snapshotting of the codes once per frame, and optional leading-zero blanking of digit 3.
- All outputs are registered and drive FPGA pins directly.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot; must be ≥ GAP_CYC+1 (simulation uses 8).
- GAP_CYC, 2, cycles at the start of each slot during which all anodes are off; legal range 0..REFRESH_DIV-1.
- BLANK_LZ, 1, when 1, digit 3 shows blank if its snapshotted code is 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  display enable; when 0, all anodes off, scanning continues.
- n_0f  in  4  code for digit 0 (rightmost).
- n_1f  in  4  code for digit 1.
- n_2f  in  4  code for digit 2.
- n_3f  in  4  code for digit 3 (leftmost).
- an  out  4  anode enables, active-low; an[i] selects digit i.
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
  - Slot counter cnt=0, digit index idx=0, snapshot registers s0..s3=0.
  - Reset mid-scan aborts immediately.
  - First snapshot occurs on the first rising edge after rst_n deasserts, with cnt=0 and idx=0.
- **Slot counter:**
  - cnt counts 0..REFRESH_DIV-1, width ceil(log2(REFRESH_DIV)).
  - At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx increments mod 4 (3→0 wraps).
- **Snapshot:**
  - On any edge where cnt==0 and idx==0, s0..s3 capture n_0f..n_3f, and frame_tick=1 on that same edge (registered); frame_tick=0 otherwise.
  - Inputs changing mid-frame do not affect display until the next frame.
- **Phases within a slot:**
  - GAP phase (cnt < GAP_CYC): next an=4'b1111, seg=7'b1111111, dp=1.
  - SHOW phase (cnt ≥ GAP_CYC): next an = ~(4'b0001<<idx) if en=1, else 4'b1111; seg/dp come from the glyph of s[idx].
- **Output timing and latency:**
  - Outputs are registered, computed from the current cnt/idx/s and registered on the same edge.
  - Outputs therefore lag the counter state by one cycle.
  - Snapshot-to-pin latency for digit 0 = GAP_CYC+1 cycles after the snapshot edge.
  - A digit's first SHOW cycle may use the snapshot taken on the same edge (digit 0 when GAP_CYC=0); the output logic must use the newly captured values.
- **Glyph map (seg, active-low {g..a}):**
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001.
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - digits 0–9: dp=1.
  - Code 10: seg=1111111, dp=0 (decimal-point-only glyph).
  - Codes 11–15: seg=1111111, dp=1 (blank).
- **Leading-zero blank:** when BLANK_LZ=1 and idx==3 and s3==0, seg=1111111, dp=1; the anode still follows the phase rules.
- **en:** affects only an; seg/dp keep their values; counters and snapshotting continue regardless of en.
- **Invariant:** at most one an bit is 0 at any time; never two digits simultaneously.

Test Plan:
(Benches use REFRESH_DIV=8, GAP_CYC=2, BLANK_LZ=1 unless stated.)
- **Reset:** assert rst_n=0 mid-SHOW of digit 2 → an=1111, seg=1111111, dp=1 asynchronously, before the next clk edge. Release → frame_tick pulses on the first edge; an=1110 after 3 cycles.
- **Scan order/timing:** codes {n3,n2,n1,n0}={0,1,10,5}, en=1.
  - Per 8-cycle slot: 2 cycles an=1111, then 6 cycles of the digit.
  - Digit 0: seg=0010010, dp=1. Digit 1: seg=1111111, dp=0. Digit 2: seg=1111001. Digit 3: blanked (seg=1111111, an=0111).
  - frame_tick every 32 cycles.
- **Tear-free snapshot:** change n_0f 5→9 during digit-2 slot → digit 0 still shows 0010010 until the next frame, then 0010000.
- **BLANK_LZ=0 / nonzero digit 3:**
  - {n3,n2,n1,n0}={1,2,10,5}: digit 3 shows 1111001.
  - With BLANK_LZ=0 and n3=0: digit 3 shows 1000000.
- **Enable:** en=0 for one full frame → an=1111 throughout, seg still cycles. Re-enable mid-slot → the anode for the current idx turns on the following cycle if in SHOW.
- **Edge parameters:**
  - GAP_CYC=0: no all-off cycles; digit 0 shows the new snapshot on the edge following capture.
  - Codes 11–15 on all digits: seg=1111111, dp=1.
  - Always assert at most one an bit low.

Source files
------------

// File: rtl/display_scan_7seg.sv
// display_scan_7seg
// Time-multiplexes four 4-bit display codes onto a 4-digit common-anode
// 7-segment display. Each digit owns a slot of REFRESH_DIV clock cycles. The
// first GAP_CYC cycles of every slot keep all anodes off so the previous
// digit's segments cannot ghost onto the next one. The four codes are
// snapshotted once per frame, at the start of digit 0's slot, so a frame
// never mixes old and new values.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          display enable (gates anodes only; scanning keeps running)
//   n_0f..n_3f  codes for digit 0 (rightmost) .. digit 3 (leftmost)
//   an          anode enables, active-low, an[i] = digit i
//   seg         segments, active-low, {g,f,e,d,c,b,a}
//   dp          decimal point, active-low
//   frame_tick  one-cycle pulse on the edge that takes a snapshot
//
// Codes 0-9 are decimal digits, code 10 lights only the decimal point, and
// codes 11-15 are blank. With BLANK_LZ=1, digit 3 is blanked when its code is 0.
module display_scan_7seg #(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYC     = 2,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] n_0f,
  input  logic [3:0] n_1f,
  input  logic [3:0] n_2f,
  input  logic [3:0] n_3f,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_s0;
  logic [3:0]       r_s1;
  logic [3:0]       r_s2;
  logic [3:0]       r_s3;

  logic             w_snap;
  logic             w_gap;
  logic             w_lz;
  logic [3:0]       w_code;
  logic [6:0]       w_glyph_seg;
  logic             w_glyph_dp;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;

  // Snapshot edge: first cycle of digit 0's slot.
  assign w_snap = (r_cnt == '0) && (r_idx == 2'd0);

  // Signed compare so that GAP_CYC=0 is simply "never in the gap".
  assign w_gap = int'(r_cnt) < GAP_CYC;

  // Digit 0's first SHOW cycle can coincide with the snapshot edge (GAP_CYC=0);
  // in that case the freshly arriving code is shown rather than the stale one.
  always_comb begin
    w_code = r_s0;
    case (r_idx)
      2'd0: w_code = w_snap ? n_0f : r_s0;
      2'd1: w_code = r_s1;
      2'd2: w_code = r_s2;
      2'd3: w_code = r_s3;
      default: w_code = r_s0;
    endcase
  end

  assign w_lz = (BLANK_LZ != 0) && (r_idx == 2'd3) && (r_s3 == 4'd0);

  // Glyph ROM, segments active-low {g,f,e,d,c,b,a}.
  always_comb begin
    w_glyph_seg = 7'b1111111;
    w_glyph_dp  = 1'b1;
    case (w_code)
      4'd0:  w_glyph_seg = 7'b1000000;
      4'd1:  w_glyph_seg = 7'b1111001;
      4'd2:  w_glyph_seg = 7'b0100100;
      4'd3:  w_glyph_seg = 7'b0110000;
      4'd4:  w_glyph_seg = 7'b0011001;
      4'd5:  w_glyph_seg = 7'b0010010;
      4'd6:  w_glyph_seg = 7'b0000010;
      4'd7:  w_glyph_seg = 7'b1111000;
      4'd8:  w_glyph_seg = 7'b0000000;
      4'd9:  w_glyph_seg = 7'b0010000;
      4'd10: w_glyph_dp  = 1'b0;
      default: begin
        w_glyph_seg = 7'b1111111;
        w_glyph_dp  = 1'b1;
      end
    endcase
  end

  // Next pin values. Only the anode depends on en; seg/dp keep following the
  // glyph so re-enabling mid-slot shows the right digit immediately.
  always_comb begin
    w_an_nxt  = 4'b1111;
    w_seg_nxt = 7'b1111111;
    w_dp_nxt  = 1'b1;
    if (!w_gap) begin
      if (en) w_an_nxt = ~(4'b0001 << r_idx);
      if (!w_lz) begin
        w_seg_nxt = w_glyph_seg;
        w_dp_nxt  = w_glyph_dp;
      end
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Per-frame snapshot of the input codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 4'd0;
      r_s1 <= 4'd0;
      r_s2 <= 4'd0;
      r_s3 <= 4'd0;
    end else if (w_snap) begin
      r_s0 <= n_0f;
      r_s1 <= n_1f;
      r_s2 <= n_2f;
      r_s3 <= n_3f;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= w_an_nxt;
      seg        <= w_seg_nxt;
      dp         <= w_dp_nxt;
      frame_tick <= w_snap;
    end
  end

endmodule

// File: tb/tb_display_scan_7seg.sv
// Bench for display_scan_7seg. Three instances share all inputs:
//   u_dut  REFRESH_DIV=8, GAP_CYC=2, BLANK_LZ=1
//   u_nlz  REFRESH_DIV=8, GAP_CYC=2, BLANK_LZ=0
//   u_g0   REFRESH_DIV=8, GAP_CYC=0, BLANK_LZ=1
// Time is counted in frame-relative edges: edge k=0 is the snapshot edge,
// and the pins after edge k reflect slot k/8, slot cycle k%8.
module tb_display_scan_7seg;

  localparam int W = 39;  // three packed {an,seg,dp,frame_tick} tuples

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] n_0f, n_1f, n_2f, n_3f;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       ft_a, ft_b, ft_c;

  logic [W-1:0] exp_q[$];
  int errors;
  int checks;

  display_scan_7seg #(.REFRESH_DIV(8), .GAP_CYC(2), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .n_0f(n_0f), .n_1f(n_1f), .n_2f(n_2f), .n_3f(n_3f),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(ft_a)
  );

  display_scan_7seg #(.REFRESH_DIV(8), .GAP_CYC(2), .BLANK_LZ(0)) u_nlz (
    .clk(clk), .rst_n(rst_n), .en(en),
    .n_0f(n_0f), .n_1f(n_1f), .n_2f(n_2f), .n_3f(n_3f),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(ft_b)
  );

  display_scan_7seg #(.REFRESH_DIV(8), .GAP_CYC(0), .BLANK_LZ(1)) u_g0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .n_0f(n_0f), .n_1f(n_1f), .n_2f(n_2f), .n_3f(n_3f),
    .an(an_c), .seg(seg_c), .dp(dp_c), .frame_tick(ft_c)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // {seg, dp} for a code, straight from the glyph table.
  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:  return {7'b1000000, 1'b1};
      4'd1:  return {7'b1111001, 1'b1};
      4'd2:  return {7'b0100100, 1'b1};
      4'd3:  return {7'b0110000, 1'b1};
      4'd4:  return {7'b0011001, 1'b1};
      4'd5:  return {7'b0010010, 1'b1};
      4'd6:  return {7'b0000010, 1'b1};
      4'd7:  return {7'b1111000, 1'b1};
      4'd8:  return {7'b0000000, 1'b1};
      4'd9:  return {7'b0010000, 1'b1};
      4'd10: return {7'b1111111, 1'b0};
      default: return {7'b1111111, 1'b1};
    endcase
  endfunction

  // Expected {an, seg, dp, frame_tick} after frame edge k.
  // codes = {n3, n2, n1, n0} as snapshotted at k=0.
  function automatic logic [12:0] exp_out(input int k, input logic [15:0] codes,
                                          input logic en_b, input int gap, input bit blz);
    int         slot;
    int         cc;
    logic [3:0] c;
    logic [3:0] a;
    logic [7:0] g;
    logic       ft;
    slot = k / 8;
    cc   = k % 8;
    ft   = (k == 0);
    c    = codes[slot*4 +: 4];
    if (cc < gap) return {4'b1111, 7'b1111111, 1'b1, ft};
    a = 4'b1111;
    if (en_b) a[slot] = 1'b0;
    g = glyph(c);
    if (blz && slot == 3 && c == 4'd0) g = {7'b1111111, 1'b1};
    return {a, g, ft};
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Runs n_cyc edges of one frame starting at the snapshot edge. Inputs hold
  // 'snap' at k=0; 'nxt' is applied just before edge chg_k; en follows en_mask[k].
  task automatic run_frame(input string tag, input logic [15:0] snap,
                           input logic [15:0] nxt, input int chg_k,
                           input logic [31:0] en_mask, input int n_cyc);
    logic [W-1:0] e;
    logic [12:0]  obs;
    {n_3f, n_2f, n_1f, n_0f} = snap;
    for (int k = 0; k < n_cyc; k++) begin
      exp_q.push_back({exp_out(k, snap, en_mask[k], 2, 1'b1),
                       exp_out(k, snap, en_mask[k], 2, 1'b0),
                       exp_out(k, snap, en_mask[k], 0, 1'b1)});
    end
    for (int k = 0; k < n_cyc; k++) begin
      en = en_mask[k];
      if (k == chg_k) {n_3f, n_2f, n_1f, n_0f} = nxt;
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s scoreboard empty at k=%0d", tag, k);
      end else begin
        e = exp_q.pop_front();
        obs = {an_a, seg_a, dp_a, ft_a};
        checks++;
        if (obs !== e[38:26]) begin
          errors++;
          $display("FAIL %s gap2_lz1 k=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
                   tag, k, obs[12:9], obs[8:2], obs[1], obs[0],
                   e[38:35], e[34:28], e[27], e[26]);
        end
        obs = {an_b, seg_b, dp_b, ft_b};
        checks++;
        if (obs !== e[25:13]) begin
          errors++;
          $display("FAIL %s gap2_lz0 k=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
                   tag, k, obs[12:9], obs[8:2], obs[1], obs[0],
                   e[25:22], e[21:15], e[14], e[13]);
        end
        obs = {an_c, seg_c, dp_c, ft_c};
        if (obs !== e[12:0]) begin
          errors++;
          $display("FAIL %s gap0_lz1 k=%0d got an=%b seg=%b dp=%b ft=%b want an=%b seg=%b dp=%b ft=%b",
                   tag, k, obs[12:9], obs[8:2], obs[1], obs[0],
                   e[12:9], e[8:2], e[1], e[0]);
        end
      end
      checks++;
      if ($countones(~an_a) > 1 || $countones(~an_b) > 1 || $countones(~an_c) > 1) begin
        errors++;
        $display("FAIL %s one_hot_anode k=%0d got an=%b/%b/%b want at most one low bit",
                 tag, k, an_a, an_b, an_c);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b1;
    en    = 1'b0;
    {n_3f, n_2f, n_1f, n_0f} = 16'h0000;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({an_a, seg_a, dp_a, ft_a} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
               an_a, seg_a, dp_a, ft_a);
    end
    checks++;
    if ({an_b, seg_b, dp_b, ft_b, an_c, seg_c, dp_c, ft_c} !==
        {4'b1111, 7'b1111111, 1'b1, 1'b0, 4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold_variants got %b/%b want 1111 1111111 1 0 on both",
               {an_b, seg_b, dp_b, ft_b}, {an_c, seg_c, dp_c, ft_c});
    end
    // Release between edges; the next rising edge is frame edge k=0.
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    // {n3,n2,n1,n0} = {0,1,10,5}
    run_frame("scan_f0", 16'h01A5, 16'h01A5, -1, 32'hFFFF_FFFF, 32);
    run_frame("scan_f1", 16'h01A5, 16'h01A5, -1, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_tear_free;
    // n_0f 5 -> 9 during digit 2's slot; this frame keeps 5, the next shows 9.
    run_frame("tear_cur", 16'h01A5, 16'h01A9, 18, 32'hFFFF_FFFF, 32);
    run_frame("tear_nxt", 16'h01A9, 16'h01A9, -1, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_nonzero_d3;
    run_frame("d3_one", 16'h12A5, 16'h12A5, -1, 32'hFFFF_FFFF, 32);
    run_frame("digits", 16'h8734, 16'h8734, -1, 32'hFFFF_FFFF, 32);
    run_frame("digits2", 16'h6092, 16'h6092, -1, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_blank_codes;
    run_frame("blank_a", 16'hFDCB, 16'hFDCB, -1, 32'hFFFF_FFFF, 32);
    run_frame("blank_b", 16'hEBFC, 16'hEBFC, -1, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_enable;
    run_frame("en_off", 16'h4321, 16'h4321, -1, 32'h0000_0000, 32);
    // Re-enable mid-slot of digit 2 (cycle 4 of the slot, already in SHOW).
    run_frame("en_mid", 16'h4321, 16'h4321, -1, 32'hFFF0_0000, 32);
  endtask

  task automatic test_reset_mid;
    // Stop after edge k=19: digit 2 is in SHOW. Reset must clear pins with no clock edge.
    run_frame("pre_rst", 16'h05A7, 16'h05A7, -1, 32'hFFFF_FFFF, 20);
    checks++;
    if (an_a !== 4'b1011) begin
      errors++;
      $display("FAIL mid_show_before_reset got an=%b want 1011", an_a);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({an_a, seg_a, dp_a, ft_a} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
               an_a, seg_a, dp_a, ft_a);
    end
    #2 rst_n = 1'b1;
    // Scanning restarts: snapshot on the first edge, digit 0 lit after 3 edges.
    run_frame("post_rst", 16'h3A05, 16'h3A05, -1, 32'hFFFF_FFFF, 32);
  endtask

  task automatic test_back_to_back;
    logic [15:0] c;
    logic [15:0] c_next;
    c = 16'($urandom_range(0, 65535));
    for (int f = 0; f < 4; f++) begin
      c_next = 16'($urandom_range(0, 65535));
      run_frame("random", c, c_next, $urandom_range(1, 31), $urandom(), 32);
      c = c_next;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_scan();
    test_tear_free();
    test_nonzero_d3();
    test_blank_codes();
    test_enable();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
